// File: rtl/power_emu_seq_ctrl.sv
// rtl/power_emu_seq_ctrl.sv - bus-master config/poll/result sequencer for the power emulator slave
// Optional poll timeout enabled by defining POWER_SEQ_TIMEOUT_EN.
module power_emu_seq_ctrl #(
  parameter int CFG_WORDS = 4,
  parameter int RES_BASE  = 5,
  parameter int POLL_GAP  = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [32*CFG_WORDS-1:0]     cfg_data,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [32*(8-RES_BASE)-1:0]  res_data,
  output logic                        m_read,
  output logic                        m_write,
  output logic [2:0]                  m_addr,
  output logic [31:0]                 m_wdata,
  input  logic [31:0]                 m_rdata
);

  localparam int NRES = 8 - RES_BASE;
  localparam int CW   = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
  localparam int GW   = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [2:0]    CFG_LAST  = 3'(CFG_WORDS - 1);
  localparam logic [2:0]    RES_FIRST = 3'(RES_BASE);
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);

  if (CFG_WORDS < 1 || CFG_WORDS > 4 || RES_BASE < 0 || RES_BASE > 7 ||
      POLL_GAP < 1 || TIMEOUT < 2) begin : g_bad_params
    $error("power_emu_seq_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_POLL_RD, S_POLL_WAIT, S_GAP, S_RES_RD, S_RES_WAIT, S_FIN
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_idx;
  logic [GW-1:0] r_gap;
  logic [31:0]   r_cfg [CFG_WORDS];
  logic [31:0]   r_res [NRES];
  logic          w_timeout;

`ifdef POWER_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_tcnt;
  logic          r_error;

  assign w_timeout = (r_tcnt == T_LAST) && !m_rdata[0];
  assign error     = r_error;

  // Counter saturates so the limit stays reached through later GAP cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt  <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_error <= 1'b0;
      end
      if (r_state == S_WR) begin
        r_tcnt <= '0;
      end else if ((r_state == S_POLL_RD || r_state == S_POLL_WAIT || r_state == S_GAP) &&
                   r_tcnt != T_LAST) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (r_state == S_POLL_WAIT && w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_gap   <= '0;
      for (int k = 0; k < CFG_WORDS; k++) r_cfg[k] <= '0;
      for (int j = 0; j < NRES; j++)      r_res[j] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx <= '0;
            for (int k = 0; k < CFG_WORDS; k++) r_cfg[k] <= cfg_data[32*k +: 32];
          end
        end
        S_WR:        r_idx <= r_idx + 3'd1;
        S_POLL_WAIT: begin
          r_idx <= RES_FIRST;
          r_gap <= '0;
        end
        S_GAP:       r_gap <= r_gap + 1'b1;
        S_RES_WAIT: begin
          for (int j = 0; j < NRES; j++) begin
            if (r_idx == 3'(RES_BASE + j)) r_res[j] <= m_rdata;
          end
          r_idx <= r_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next  = r_state;
    done    = 1'b0;
    m_read  = 1'b0;
    m_write = 1'b0;
    m_addr  = 3'd0;
    m_wdata = 32'd0;
    case (r_state)
      S_IDLE:      if (start) w_next = S_WR;
      S_WR: begin
        m_write = 1'b1;
        m_addr  = r_idx;
        m_wdata = r_cfg[r_idx[CW-1:0]];
        if (r_idx == CFG_LAST) w_next = S_POLL_RD;
      end
      S_POLL_RD: begin
        m_read = 1'b1;
        m_addr = 3'd7;
        w_next = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (m_rdata[0])     w_next = S_RES_RD;
        else if (w_timeout) w_next = S_FIN;
        else                w_next = S_GAP;
      end
      S_GAP:       if (r_gap == GAP_LAST) w_next = S_POLL_RD;
      S_RES_RD: begin
        m_read = 1'b1;
        m_addr = r_idx;
        w_next = S_RES_WAIT;
      end
      S_RES_WAIT:  w_next = (r_idx == 3'd7) ? S_FIN : S_RES_RD;
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:     w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  for (genvar j = 0; j < NRES; j++) begin : g_res
    assign res_data[32*j +: 32] = r_res[j];
  end

endmodule

// File: tb/tb_power_emu_seq_ctrl.sv
// tb/tb_power_emu_seq_ctrl.sv - directed self-checking bench for power_emu_seq_ctrl
module tb_power_emu_seq_ctrl;

  localparam int CFG_WORDS = 4;
  localparam int RES_BASE  = 5;
  localparam int POLL_GAP  = 4;
  localparam int TIMEOUT   = 16;
  localparam int NRES      = 8 - RES_BASE;
  localparam logic [95:0]  EXP_RES = {32'h0000_0001, 32'h5A5A_5A5A, 32'hA5A5_A5A5};
  localparam logic [127:0] CFG_A   = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [127:0] CFG_B   = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      start = 1'b0;
  logic [32*CFG_WORDS-1:0]   cfg_data = '0;
  logic                      busy, done, error, m_read, m_write;
  logic [32*NRES-1:0]        res_data;
  logic [2:0]                m_addr;
  logic [31:0]               m_wdata;
  logic [31:0]               m_rdata = '0;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0, wr_n = 0, done_cnt = 0, both_cnt = 0, res_reads = 0;
  int poll_reads = 0, strobe_cnt = 0, fail_polls = 0;
  bit never_ready = 1'b0;
  logic [2:0]  wr_addr [8];
  logic [31:0] wr_data [8];
  int          wr_cyc  [8];

  always #5 clk = ~clk;

  power_emu_seq_ctrl #(
    .CFG_WORDS(CFG_WORDS), .RES_BASE(RES_BASE), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .res_data(res_data),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // Slave model and bus monitor; cyc_cnt is 1 in the cycle right after start is accepted.
  always @(posedge clk) begin
    if (reset_n) begin
      if (m_write && wr_n < 8) begin
        wr_addr[wr_n] = m_addr;
        wr_data[wr_n] = m_wdata;
        wr_cyc[wr_n]  = cyc_cnt;
        wr_n++;
      end
      if (m_read && m_write) both_cnt++;
      if (m_read || m_write) strobe_cnt++;
      if (done) done_cnt++;
      if (m_read) begin
        if (m_addr == 3'd7) begin
          m_rdata <= {31'd0, (!never_ready && poll_reads >= fail_polls)};
          poll_reads++;
        end else if (m_addr == 3'd5) begin
          m_rdata <= 32'hA5A5_A5A5;
          res_reads++;
        end else if (m_addr == 3'd6) begin
          m_rdata <= 32'h5A5A_5A5A;
          res_reads++;
        end else begin
          m_rdata <= 32'hDEAD_BEEF;
        end
      end
      if (start && !busy) cyc_cnt = 1;
      else                cyc_cnt++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_n = 0; done_cnt = 0; both_cnt = 0; res_reads = 0;
    poll_reads = 0; strobe_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_m_read"}, m_read, 1'b0);
    check({tag, "_m_write"}, m_write, 1'b0);
    check({tag, "_m_addr"}, m_addr, 3'd0);
    check({tag, "_m_wdata"}, m_wdata, 32'd0);
    check({tag, "_res_data"}, res_data, 96'd0);
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(negedge clk);
    check_outputs_reset("por");
    reset_n = 1'b1;

    // Basic pass: status set on first poll
    cfg_data = CFG_A;
    clear_logs();
    pulse_start();
    check("basic_busy_c1", busy, 1'b1);
    wait_done(200);
    check("basic_done_cycle", cyc_cnt, 13);
    check("basic_error", error, 1'b0);
    check("basic_res", res_data, EXP_RES);
    check("basic_wr_count", wr_n, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("basic_wr%0d_addr", k), wr_addr[k], 3'(k));
      check($sformatf("basic_wr%0d_data", k), wr_data[k], CFG_A[32*k +: 32]);
      check($sformatf("basic_wr%0d_cycle", k), wr_cyc[k], k + 1);
    end
    @(negedge clk);
    check("basic_busy_after", busy, 1'b0);
    check("basic_done_pulses", done_cnt, 1);

    // Polling: three failed polls, each adding 2+POLL_GAP cycles
    clear_logs();
    fail_polls = 3;
    pulse_start();
    wait_done(200);
    check("poll_done_cycle", cyc_cnt, 31);
    check("poll_status_reads", poll_reads, 5);
    check("poll_strobes", strobe_cnt, 11);
    check("poll_res", res_data, EXP_RES);
    fail_polls = 0;
    @(negedge clk);

    // Busy collision: start pulses at cycles 3 and 13 are ignored
    clear_logs();
    pulse_start();
    repeat (2) @(negedge clk);
    check("coll_cycle3", cyc_cnt, 3);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(200);
    check("coll_done_cycle", cyc_cnt, 13);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (20) @(negedge clk);
    check("coll_done_pulses", done_cnt, 1);
    check("coll_busy_idle", busy, 1'b0);
    check("coll_wr_count", wr_n, 4);

    // Back-to-back: restart in the cycle after done
    clear_logs();
    pulse_start();
    wait_done(200);
    check("b2b_first_done", cyc_cnt, 13);
    @(negedge clk);
    cfg_data = CFG_B;
    start    = 1'b1;
    @(negedge clk) start = 1'b0;
    check("b2b_busy_c1", busy, 1'b1);
    check("b2b_cycle1", cyc_cnt, 1);
    check("b2b_write_c1", m_write, 1'b1);
    check("b2b_addr_c1", m_addr, 3'd0);
    check("b2b_wdata_c1", m_wdata, CFG_B[31:0]);
    wait_done(200);
    check("b2b_second_done", cyc_cnt, 13);
    check("b2b_wr_count", wr_n, 8);
    check("b2b_wr7_data", wr_data[7], CFG_B[127:96]);
    check("b2b_both_high", both_cnt, 0);

`ifdef POWER_SEQ_TIMEOUT_EN
    // Timeout: status never set
    @(negedge clk);
    clear_logs();
    never_ready = 1'b1;
    pulse_start();
    wait_done(200);
    check("to_done_cycle", cyc_cnt, 25);
    check("to_error", error, 1'b1);
    check("to_res_reads", res_reads, 0);
    check("to_res_kept", res_data, EXP_RES);
    @(negedge clk);
    check("to_error_held", error, 1'b1);
    never_ready = 1'b0;
    clear_logs();
    pulse_start();
    check("to_error_cleared", error, 1'b0);
    wait_done(200);
    check("to_recover_error", error, 1'b0);
    check("to_recover_cycle", cyc_cnt, 13);
`endif

    // Reset during WR at cycle 2 aborts asynchronously
    @(negedge clk);
    clear_logs();
    pulse_start();
    @(negedge clk);
    check("rst_cycle2_write", m_write, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_outputs_reset("rst_mid");
    repeat (3) @(negedge clk);
    reset_n    = 1'b1;
    strobe_cnt = 0;
    repeat (20) @(negedge clk);
    check("rst_no_strobes", strobe_cnt, 0);
    check("rst_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
